// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - FSM states, reconfig register map and per-mode PLL tables
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_MODE,
    ST_TABLE,
    ST_START,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_ERROR
  } state_t;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_PHASE = 6'h06;
  localparam logic [5:0] ADDR_K     = 6'h07;

  localparam int         TABLE_MAX      = 11;
  localparam logic [3:0] TABLE_LEN_NTSC = 4'd11;
  localparam logic [3:0] TABLE_LEN_PAL  = 4'd11;

  typedef logic [37:0] table_entry_t;

  // C data: [22:18] counter select, [15:8] high, [7:0] low; phase data: [21] up, [20:16] counter, [15:0] steps
  localparam table_entry_t NTSC_TABLE [TABLE_MAX] = '{
    {ADDR_M,     32'h0000_0808},
    {ADDR_N,     32'h0001_0000},
    {ADDR_K,     32'h2B9F_0E13},
    {ADDR_C,     32'h0000_0B0A},
    {ADDR_C,     32'h0004_1616},
    {ADDR_C,     32'h0008_2C2C},
    {ADDR_C,     32'h000C_0B0A},
    {ADDR_C,     32'h0010_1616},
    {ADDR_C,     32'h0014_0B0A},
    {ADDR_PHASE, 32'h0023_0010},
    {ADDR_PHASE, 32'h0025_0020}
  };

  localparam table_entry_t PAL_TABLE [TABLE_MAX] = '{
    {ADDR_M,     32'h0000_0808},
    {ADDR_N,     32'h0001_0000},
    {ADDR_K,     32'h1E4B_6A2C},
    {ADDR_C,     32'h0000_0B0A},
    {ADDR_C,     32'h0004_1616},
    {ADDR_C,     32'h0008_2C2C},
    {ADDR_C,     32'h000C_0B0A},
    {ADDR_C,     32'h0010_1616},
    {ADDR_C,     32'h0014_0B0A},
    {ADDR_PHASE, 32'h0023_0011},
    {ADDR_PHASE, 32'h0025_0022}
  };

endpackage

// File: rtl/pll_reconfig_table.sv
// rtl/pll_reconfig_table.sv - combinational (mode, index) -> {addr, data, last} lookup
module pll_reconfig_table
  import pll_reconfig_pkg::*;
(
  input  logic        mode,
  input  logic [3:0]  index,
  output logic [5:0]  addr,
  output logic [31:0] data,
  output logic        last
);

  table_entry_t entry;
  logic [3:0]   len;

  always_comb begin
    len   = mode ? TABLE_LEN_PAL : TABLE_LEN_NTSC;
    entry = '0;
    if (index < len) begin
      entry = mode ? PAL_TABLE[index] : NTSC_TABLE[index];
    end
    addr = entry[37:32];
    data = entry[31:0];
    last = (index == len - 4'd1);
  end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// rtl/pll_reconfig_sequencer.sv - NTSC/PAL PLL reprogramming sequencer and lock supervisor
module pll_reconfig_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        mode_req,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic        core_reset,
  output logic        busy,
  output logic        mode_active,
  output logic        error
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t        state, state_d;
  logic          sync1, locked_s;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] lock_timer;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] retry, retry_d;
  logic [3:0]    idx, idx_d;
  logic          target, target_d, mode_active_d, wr_d;
  logic [5:0]    addr_d, tbl_addr;
  logic [31:0]   data_d, tbl_data;
  logic          tbl_last;

  pll_reconfig_table u_table (
    .mode  (target),
    .index (idx),
    .addr  (tbl_addr),
    .data  (tbl_data),
    .last  (tbl_last)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state          <= ST_STABLE;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      retry          <= '0;
      target         <= 1'b0;
      mode_active    <= 1'b0;
      idx            <= '0;
    end else begin
      state          <= state_d;
      mgmt_write     <= wr_d;
      mgmt_address   <= addr_d;
      mgmt_writedata <= data_d;
      retry          <= retry_d;
      target         <= target_d;
      mode_active    <= mode_active_d;
      idx            <= idx_d;
    end
  end

  // Each timer runs only in its own state and saturates at its limit.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      lock_timer <= '0;
      stable_cnt <= '0;
    end else begin
      if (state != ST_HOLD)                   hold_cnt <= '0;
      else if (hold_cnt != HW'(HOLD_CYCLES))  hold_cnt <= hold_cnt + 1'b1;

      if (state != ST_WAIT_LOCK)               lock_timer <= '0;
      else if (lock_timer != TW'(LOCK_TIMEOUT)) lock_timer <= lock_timer + 1'b1;

      if (state != ST_STABLE || !locked_s)     stable_cnt <= '0;
      else if (stable_cnt != SW'(LOCK_STABLE)) stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d       = state;
    wr_d          = mgmt_write;
    addr_d        = mgmt_address;
    data_d        = mgmt_writedata;
    retry_d       = retry;
    target_d      = target;
    mode_active_d = mode_active;
    idx_d         = idx;
    case (state)
      ST_IDLE: begin
        if (!locked_s) begin
          state_d = ST_STABLE;
        end else if (mode_req != mode_active) begin
          state_d  = ST_HOLD;
          target_d = mode_req;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_d = ST_MODE;
      end
      ST_MODE, ST_TABLE, ST_START: begin
        // Idle cycle issues the write; it then holds until waitrequest drops.
        if (mgmt_write) begin
          if (!mgmt_waitrequest) begin
            wr_d = 1'b0;
            case (state)
              ST_MODE: begin
                state_d = ST_TABLE;
                idx_d   = '0;
              end
              ST_TABLE: begin
                if (tbl_last) state_d = ST_START;
                else          idx_d   = idx + 4'd1;
              end
              default: state_d = ST_WAIT_LOCK;
            endcase
          end
        end else begin
          wr_d = 1'b1;
          case (state)
            ST_MODE: begin
              addr_d = ADDR_MODE;
              data_d = 32'd1;
            end
            ST_TABLE: begin
              addr_d = tbl_addr;
              data_d = tbl_data;
            end
            default: begin
              addr_d = ADDR_START;
              data_d = 32'd0;
            end
          endcase
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (lock_timer == TW'(LOCK_TIMEOUT)) begin
          retry_d = retry + 1'b1;
          state_d = (retry_d == RW'(MAX_RETRIES)) ? ST_ERROR : ST_HOLD;
        end
      end
      ST_STABLE: begin
        if (locked_s && stable_cnt == SW'(LOCK_STABLE - 1)) begin
          state_d       = ST_IDLE;
          mode_active_d = target;
          retry_d       = '0;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  assign mgmt_read  = 1'b0;
  assign core_reset = (state != ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign error      = (state == ST_ERROR);

endmodule
